iob_eth_rx_mac: RTL and testbench

Parametrised MII receive MAC for the iob-eth core; generalises the single-frame receiver with configurable buffer depth, frame length limits, error/runt/oversize rejection, destination-MAC filtering and on-chip FCS verdict. Sits between the PHY MII RX pins and the RX frame buffer RAM. Writes one byte per two RX_CLK cycles into the buffer and presents a level-held frame-ready flag until the system acknowledges it. Instantiates `iob_eth_crc` for the FCS check.

---
 rtl/iob_eth_rx_mac_pkg.sv | 34 +++
 rtl/iob_eth_crc.sv | 45 ++++
 rtl/iob_eth_rx_mac.sv | 258 +++++++++++++++++++++++++
 tb/tb_iob_eth_rx_mac.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_eth_rx_mac_pkg
// Description : Shared definitions for the iob-eth MII receive MAC: receiver
//               state encoding, Ethernet framing constants, the default
//               station address and a helper that extracts one wire-order
//               byte from a 48-bit MAC address.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_eth_rx_mac_pkg;

   // Receiver states
   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      PRE       = 3'd1,
      DATA      = 3'd2,
      DROP      = 3'd3,
      DONE      = 3'd4
   } rx_state_t;

   localparam logic [7:0]  ETH_SFD          = 8'hD5;
   localparam logic [31:0] ETH_CRC_RESIDUE  = 32'hC704DD7B;
   localparam logic [31:0] ETH_CRC_POLY     = 32'h04C11DB7;
   localparam logic [47:0] ETH_BCAST        = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] ETH_MAC_ADDR_DEF = 48'h0;

   // Byte idx (0 = first on the wire) of a MAC address; byte 0 is [47:40].
   function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                           input logic [2:0]  idx);
      return mac[47 - 8*int'(idx) -: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/iob_eth_crc.sv
`default_nettype none
// ============================================================================
// Module      : iob_eth_crc
// Description : Byte-wide Ethernet CRC-32 engine. The register is kept in
//               MSB-first form while each byte is consumed LSB first (wire
//               order), so after a good frame plus its FCS the register holds
//               the fixed residue 32'hC704DD7B.
// Ports       : rst     in   asynchronous active-high reset
//               clk     in   clock
//               start   in   reload the register with all ones
//               data_in in 8 byte to absorb
//               data_en in   absorb data_in this cycle
//               crc_out out 32 current register value
// Revision    : 1.0 - initial release
// ============================================================================
module iob_eth_crc
   import iob_eth_rx_mac_pkg::*;
(
   input  logic        rst,
   input  logic        clk,
   input  logic        start,
   input  logic [7:0]  data_in,
   input  logic        data_en,
   output logic [31:0] crc_out
);

   function automatic logic [31:0] crc_next(input logic [31:0] c,
                                            input logic [7:0]  d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ ETH_CRC_POLY;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          crc_out <= 32'hFFFF_FFFF;
      else if (start)   crc_out <= 32'hFFFF_FFFF;
      else if (data_en) crc_out <= crc_next(crc_out, data_in);
   end

endmodule
`default_nettype wire

// File: rtl/iob_eth_rx_mac.sv
`default_nettype none
// ============================================================================
// Module      : iob_eth_rx_mac
// Description : MII receive MAC. Hunts for the SFD, assembles nibbles into
//               bytes, writes them to the frame buffer (one byte every two
//               RX_CLK cycles), rejects errored/runt/oversize/odd-nibble
//               frames, checks the FCS residue and holds an accepted frame
//               until the system acknowledges it.
//               Build option IOB_ETH_RX_MAC_FILTER_EN: when defined, only
//               frames addressed to ETH_MAC_ADDR or broadcast are accepted;
//               when undefined the receiver is promiscuous.
// Ports       : RX_CLK    in            MII receive clock
//               rst       in            asynchronous active-high reset
//               RX_DV     in            MII data valid
//               RX_ER     in            MII receive error
//               RX_DATA   in  4         MII nibble, low nibble first
//               rcv_ack   in            system pulse releasing the buffer
//               addr      out ADDR_W    buffer write address
//               data      out 8         buffer write byte
//               wr        out           buffer write strobe
//               data_rcvd out           accepted frame held in buffer
//               rx_nbytes out ADDR_W+1  accepted length, FCS included
//               crc_ok    out           FCS residue correct
//               drop_cnt  out 16        saturating dropped-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module iob_eth_rx_mac
   import iob_eth_rx_mac_pkg::*;
#(
   parameter logic [47:0] ETH_MAC_ADDR = ETH_MAC_ADDR_DEF,
   parameter int          ADDR_W       = 11,
   parameter int          MAX_FRAME    = 1518,
   parameter int          MIN_FRAME    = 64
)(
   input  logic              RX_CLK,
   input  logic              rst,
   input  logic              RX_DV,
   input  logic              RX_ER,
   input  logic [3:0]        RX_DATA,
   input  logic              rcv_ack,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data,
   output logic              wr,
   output logic              data_rcvd,
   output logic [ADDR_W:0]   rx_nbytes,
   output logic              crc_ok,
   output logic [15:0]       drop_cnt
);

   localparam logic [ADDR_W:0] c_max_frame = MAX_FRAME[ADDR_W:0];
   localparam logic [ADDR_W:0] c_min_frame = MIN_FRAME[ADDR_W:0];

   // ------------------------------------------------------------------
   // Reset and acknowledge synchronisers
   // ------------------------------------------------------------------
   logic [1:0] r_rst_sync;
   logic [1:0] r_ack_sync;
   logic       w_rst_s;
   logic       w_ack_s;

   always_ff @(posedge RX_CLK or posedge rst) begin
      if (rst) r_rst_sync <= 2'b11;
      else     r_rst_sync <= {r_rst_sync[0], 1'b0};
   end
   assign w_rst_s = r_rst_sync[1];

   // The ack pulse comes from another clock domain and may be shorter than
   // an RX_CLK period, so it presets the chain instead of being sampled.
   always_ff @(posedge RX_CLK or posedge rcv_ack) begin
      if (rcv_ack) r_ack_sync <= 2'b11;
      else         r_ack_sync <= {r_ack_sync[0], 1'b0};
   end
   assign w_ack_s = r_ack_sync[1];

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   rx_state_t       r_state;
   rx_state_t       w_state_nxt;
   logic [3:0]      r_prev_nib;
   logic [3:0]      r_low_nib;
   logic            r_phase;
   logic            r_rx_dv_d;
   logic [ADDR_W:0] r_byte_cnt;
   logic [31:0]     w_crc;
   logic [7:0]      w_rx_byte;
   logic            w_mac_bad;

   // Control strobes from the next-state logic
   logic w_enter_pre;
   logic w_lat_low;
   logic w_write;
   logic w_drop;
   logic w_done_set;
   logic w_done_ack;

   assign w_rx_byte = {RX_DATA, r_low_nib};

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge RX_CLK or posedge w_rst_s) begin
      if (w_rst_s) r_state <= WAIT_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enter_pre = 1'b0;
      w_lat_low   = 1'b0;
      w_write     = 1'b0;
      w_drop      = 1'b0;
      w_done_set  = 1'b0;
      w_done_ack  = 1'b0;
      case (r_state)
         WAIT_IDLE: begin
            // A quiet line is required before hunting, so a frame already
            // in flight after reset or a drop is never picked up mid-way.
            if (!RX_DV) begin
               w_state_nxt = PRE;
               w_enter_pre = 1'b1;
            end
         end
         PRE: begin
            if (RX_DV && ({RX_DATA, r_prev_nib} == ETH_SFD))
               w_state_nxt = DATA;
         end
         DATA: begin
            if (!RX_DV) begin
               if (r_phase || (r_byte_cnt < c_min_frame) || w_mac_bad)
                  w_state_nxt = DROP;
               else
                  w_state_nxt = DONE;
            end else if (RX_ER) begin
               w_state_nxt = DROP;
            end else if (!r_phase) begin
               w_lat_low = 1'b1;
            end else if (r_byte_cnt == c_max_frame) begin
               // One byte past the limit: reject without writing it.
               w_state_nxt = DROP;
            end else begin
               w_write = 1'b1;
            end
         end
         DROP: begin
            w_drop      = 1'b1;
            w_state_nxt = WAIT_IDLE;
         end
         DONE: begin
            w_done_set = !data_rcvd;
            // Ack takes priority over a colliding new frame start.
            if (data_rcvd && w_ack_s) begin
               w_done_ack  = 1'b1;
               w_state_nxt = WAIT_IDLE;
            end else if (RX_DV && !r_rx_dv_d) begin
               w_drop = 1'b1;
            end
         end
         default: w_state_nxt = WAIT_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge RX_CLK or posedge w_rst_s) begin
      if (w_rst_s) begin
         r_prev_nib <= 4'h0;
         r_low_nib  <= 4'h0;
         r_phase    <= 1'b0;
         r_rx_dv_d  <= 1'b0;
         r_byte_cnt <= '0;
         addr       <= '0;
         data       <= 8'h00;
         wr         <= 1'b0;
         data_rcvd  <= 1'b0;
         rx_nbytes  <= '0;
         crc_ok     <= 1'b0;
         drop_cnt   <= 16'h0000;
      end else begin
         r_prev_nib <= RX_DATA;
         r_rx_dv_d  <= RX_DV;
         wr         <= w_write;

         if (w_lat_low) r_low_nib <= RX_DATA;

         if (w_enter_pre)    r_phase <= 1'b0;
         else if (w_lat_low) r_phase <= 1'b1;
         else if (w_write)   r_phase <= 1'b0;

         if (w_enter_pre)  r_byte_cnt <= '0;
         else if (w_write) r_byte_cnt <= r_byte_cnt + 1'b1;

         if (w_write) data <= w_rx_byte;

         // Address advances the cycle after each strobe.
         if (w_enter_pre) addr <= '0;
         else if (wr)     addr <= addr + 1'b1;

         if (w_drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;

         if (w_done_ack) begin
            data_rcvd <= 1'b0;
         end else if (w_done_set) begin
            data_rcvd <= 1'b1;
            rx_nbytes <= r_byte_cnt;
            crc_ok    <= (w_crc == ETH_CRC_RESIDUE);
         end
      end
   end

   // ------------------------------------------------------------------
   // Destination address filter
   // ------------------------------------------------------------------
`ifdef IOB_ETH_RX_MAC_FILTER_EN
   localparam logic [ADDR_W:0] c_hdr_len = 6;

   logic r_uc_match;
   logic r_bc_match;

   always_ff @(posedge RX_CLK or posedge w_rst_s) begin
      if (w_rst_s) begin
         r_uc_match <= 1'b1;
         r_bc_match <= 1'b1;
      end else if (w_enter_pre) begin
         r_uc_match <= 1'b1;
         r_bc_match <= 1'b1;
      end else if (w_write && (r_byte_cnt < c_hdr_len)) begin
         r_uc_match <= r_uc_match &
                       (w_rx_byte == mac_byte(ETH_MAC_ADDR, r_byte_cnt[2:0]));
         r_bc_match <= r_bc_match &
                       (w_rx_byte == mac_byte(ETH_BCAST, r_byte_cnt[2:0]));
      end
   end

   assign w_mac_bad = ~(r_uc_match | r_bc_match);
`else
   logic w_unused_mac;

   assign w_mac_bad    = 1'b0;
   assign w_unused_mac = ^ETH_MAC_ADDR;
`endif

   // ------------------------------------------------------------------
   // FCS check: held at init during preamble, fed by each buffer write
   // ------------------------------------------------------------------
   iob_eth_crc u_crc (
      .rst     (w_rst_s),
      .clk     (RX_CLK),
      .start   (r_state == PRE),
      .data_in (data),
      .data_en (wr),
      .crc_out (w_crc)
   );

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_rx_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_eth_rx_mac
// Description : Self-checking bench for iob_eth_rx_mac. Frames are built with
//               a reflected-form FCS, sent over MII, and every expected
//               buffer write is queued and matched against the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_eth_rx_mac;

   localparam logic [47:0] MAC    = 48'h0A1B_2C3D_4E5F;
   localparam logic [47:0] OTHER  = 48'h0200_0000_0001;
   localparam int          ADDR_W = 11;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic              RX_CLK  = 1'b0;
   logic              rst     = 1'b1;
   logic              RX_DV   = 1'b0;
   logic              RX_ER   = 1'b0;
   logic [3:0]        RX_DATA = 4'h0;
   logic              rcv_ack = 1'b0;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data;
   logic              wr;
   logic              data_rcvd;
   logic [ADDR_W:0]   rx_nbytes;
   logic              crc_ok;
   logic [15:0]       drop_cnt;

   iob_eth_rx_mac #(
      .ETH_MAC_ADDR (MAC),
      .ADDR_W       (ADDR_W),
      .MAX_FRAME    (1518),
      .MIN_FRAME    (64)
   ) dut (
      .RX_CLK    (RX_CLK),
      .rst       (rst),
      .RX_DV     (RX_DV),
      .RX_ER     (RX_ER),
      .RX_DATA   (RX_DATA),
      .rcv_ack   (rcv_ack),
      .addr      (addr),
      .data      (data),
      .wr        (wr),
      .data_rcvd (data_rcvd),
      .rx_nbytes (rx_nbytes),
      .crc_ok    (crc_ok),
      .drop_cnt  (drop_cnt)
   );

   always #10 RX_CLK = ~RX_CLK;

   int checks    = 0;
   int errors    = 0;
   int exp_drops = 0;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } wr_t;

   typedef struct {
      int len;    // bytes incl. FCS
      int dest;   // 0 own, 1 broadcast, 2 other unicast
      bit bad;    // corrupt last FCS byte
      int er_at;  // byte index carrying RX_ER, -1 none
      bit xnib;   // append a stray nibble
      bit rcvd;   // expected accepted
      bit crc;    // expected crc_ok when accepted
      int nwr;    // expected buffer writes
   } vec_t;

   wr_t        sb[$];
   wr_t        mon_e;
   logic [7:0] frame[$];
   logic [7:0] frame_a[$];
   logic [7:0] mem [0:2047];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Write monitor / scoreboard
   always @(negedge RX_CLK) begin
      if (wr === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got write addr %0d data %h, expected none",
                     addr, data);
         end else begin
            mon_e = sb.pop_front();
            if (addr !== mon_e.a || data !== mon_e.d) begin
               errors++;
               $display("FAIL wr_data: got addr %0d data %h, expected addr %0d data %h",
                        addr, data, mon_e.a, mon_e.d);
            end
         end
         mem[addr] = data;
      end
   end

   function automatic logic [31:0] fcs_calc(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, frame[i]};
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build_frame(input int len, input int dest, input bit bad);
      logic [47:0] da;
      logic [31:0] f;
      logic [7:0]  b;
      da = (dest == 0) ? MAC : (dest == 1) ? 48'hFFFF_FFFF_FFFF : OTHER;
      frame.delete();
      for (int i = 0; i < 6; i++)  frame.push_back(da[47-8*i -: 8]);
      for (int i = 0; i < 6; i++)  frame.push_back(8'h10 + 8'(i));
      for (int i = 12; i < len - 4; i++) frame.push_back(8'($urandom_range(0, 255)));
      f = fcs_calc(len - 4);
      for (int i = 0; i < 4; i++)  frame.push_back(f[8*i +: 8]);
      if (bad) begin
         b = frame[len-1];
         frame[len-1] = ~b;
      end
   endtask

   task automatic tick_nib(input logic dv, input logic er, input logic [3:0] n);
      @(negedge RX_CLK);
      RX_DV   = dv;
      RX_ER   = er;
      RX_DATA = n;
   endtask

   task automatic send_frame(input int nwr, input int er_at, input int rst_at,
                             input bit xnib);
      logic [7:0] b;
      logic       er;
      for (int i = 0; i < 15; i++) tick_nib(1'b1, 1'b0, 4'h5);
      tick_nib(1'b1, 1'b0, 4'hD);
      for (int i = 0; i < frame.size(); i++) begin
         b  = frame[i];
         er = (i == er_at);
         tick_nib(1'b1, er, b[3:0]);
         if (i == rst_at) begin
            #1 rst = 1'b1;
         end
         tick_nib(1'b1, er, b[7:4]);
         if (i < nwr) sb.push_back('{a: ADDR_W'(i), d: b});
         if (i == rst_at) begin
            #1;
            chk("rst.addr",      32'(addr),      32'd0);
            chk("rst.data",      32'(data),      32'd0);
            chk("rst.wr",        32'(wr),        32'd0);
            chk("rst.data_rcvd", 32'(data_rcvd), 32'd0);
            chk("rst.rx_nbytes", 32'(rx_nbytes), 32'd0);
            chk("rst.crc_ok",    32'(crc_ok),    32'd0);
            chk("rst.drop_cnt",  32'(drop_cnt),  32'd0);
            rst       = 1'b0;
            exp_drops = 0;
         end
      end
      if (xnib) tick_nib(1'b1, 1'b0, 4'h3);
      tick_nib(1'b0, 1'b0, 4'h0);
   endtask

   task automatic expect_outcome(input string tag, input bit rcvd,
                                 input int nbytes, input bit crc);
      int k;
      if (rcvd) begin
         k = 0;
         while (data_rcvd !== 1'b1 && k < 10) begin
            @(negedge RX_CLK);
            k++;
         end
         chk({tag, ".data_rcvd"}, 32'(data_rcvd), 32'd1);
         chk({tag, ".rx_nbytes"}, 32'(rx_nbytes), 32'(nbytes));
         chk({tag, ".crc_ok"},    32'(crc_ok),    32'(crc));
      end else begin
         exp_drops++;
         repeat (8) @(negedge RX_CLK);
         chk({tag, ".data_rcvd"}, 32'(data_rcvd), 32'd0);
      end
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
      chk({tag, ".writes_left"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic ack_and_check(input string tag);
      int k;
      @(negedge RX_CLK);
      #3 rcv_ack = 1'b1;
      #2 rcv_ack = 1'b0;
      k = 0;
      while (data_rcvd !== 1'b0 && k < 3) begin
         @(posedge RX_CLK);
         #1;
         k++;
      end
      chk({tag, ".ack_release"}, 32'(data_rcvd), 32'd0);
      repeat (4) @(negedge RX_CLK);
   endtask

   vec_t tbl[10];

   initial begin
      int bad_bytes;
      tbl[0] = '{64,   0, 1'b0, -1, 1'b0, 1'b1,  1'b1, 64};
      tbl[1] = '{100,  1, 1'b1, -1, 1'b0, 1'b1,  1'b0, 100};
      tbl[2] = '{64,   2, 1'b0, -1, 1'b0, !FILT, 1'b1, 64};
      tbl[3] = '{80,   0, 1'b0, 20, 1'b0, 1'b0,  1'b0, 20};
      tbl[4] = '{64,   0, 1'b0, -1, 1'b0, 1'b1,  1'b1, 64};
      tbl[5] = '{40,   0, 1'b0, -1, 1'b0, 1'b0,  1'b0, 40};
      tbl[6] = '{63,   1, 1'b0, -1, 1'b0, 1'b0,  1'b0, 63};
      tbl[7] = '{64,   0, 1'b0, -1, 1'b1, 1'b0,  1'b0, 64};
      tbl[8] = '{1519, 0, 1'b0, -1, 1'b0, 1'b0,  1'b0, 1518};
      tbl[9] = '{1518, 1, 1'b0, -1, 1'b0, 1'b1,  1'b1, 1518};

      repeat (3) @(negedge RX_CLK);
      chk("init.addr",      32'(addr),      32'd0);
      chk("init.wr",        32'(wr),        32'd0);
      chk("init.data_rcvd", 32'(data_rcvd), 32'd0);
      chk("init.drop_cnt",  32'(drop_cnt),  32'd0);
      rst = 1'b0;
      repeat (4) @(negedge RX_CLK);

      for (int v = 0; v < 10; v++) begin
         build_frame(tbl[v].len, tbl[v].dest, tbl[v].bad);
         send_frame(tbl[v].nwr, tbl[v].er_at, -1, tbl[v].xnib);
         expect_outcome($sformatf("vec%0d", v), tbl[v].rcvd, tbl[v].len, tbl[v].crc);
         if (tbl[v].rcvd) ack_and_check($sformatf("vec%0d", v));
      end

      // Frame B arrives while frame A is held
      build_frame(64, 0, 1'b0);
      frame_a = frame;
      send_frame(64, -1, -1, 1'b0);
      expect_outcome("hold.a", 1'b1, 64, 1'b1);
      build_frame(70, 0, 1'b0);
      send_frame(0, -1, -1, 1'b0);
      repeat (8) @(negedge RX_CLK);
      exp_drops++;
      chk("hold.drop_cnt",  32'(drop_cnt),  32'(exp_drops));
      chk("hold.data_rcvd", 32'(data_rcvd), 32'd1);
      chk("hold.rx_nbytes", 32'(rx_nbytes), 32'd64);
      bad_bytes = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== frame_a[i]) bad_bytes++;
      chk("hold.buffer_a", 32'(bad_bytes), 32'd0);
      ack_and_check("hold");
      build_frame(72, 1, 1'b0);
      send_frame(72, -1, -1, 1'b0);
      expect_outcome("hold.c", 1'b1, 72, 1'b1);
      ack_and_check("hold.c");

      // Reset in the middle of a frame, then a good frame
      build_frame(64, 0, 1'b0);
      send_frame(30, -1, 30, 1'b0);
      repeat (8) @(negedge RX_CLK);
      chk("rstf.data_rcvd", 32'(data_rcvd), 32'd0);
      chk("rstf.drop_cnt",  32'(drop_cnt),  32'd0);
      chk("rstf.writes_left", 32'(sb.size()), 32'd0);
      build_frame(64, 0, 1'b0);
      send_frame(64, -1, -1, 1'b0);
      expect_outcome("rstf.next", 1'b1, 64, 1'b1);
      ack_and_check("rstf.next");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
